// File: rtl/adder_share_arb_pkg.sv
// -----------------------------------------------------------------------------
// adder_share_arb_pkg
// Shared constants and helpers for the shared-adder arbiter.
//   ADD_W    : datapath width of the shared adder (32)
//   MAX_REQ  : largest supported requester count (16)
//   BUS_W    : width of a zero-extended packed operand bus (MAX_REQ*ADD_W)
//   op_slice : extracts requester idx's operand from a packed operand bus
// -----------------------------------------------------------------------------
package adder_share_arb_pkg;

    localparam int ADD_W   = 32;
    localparam int MAX_REQ = 16;
    localparam int BUS_W   = MAX_REQ * ADD_W;

    // Operand i sits at bits [ADD_W*i +: ADD_W] of the packed bus.
    function automatic logic [ADD_W-1:0] op_slice(
        input logic [BUS_W-1:0] bus,
        input int               idx
    );
        return bus[idx*ADD_W +: ADD_W];
    endfunction

endpackage

// File: rtl/adder_32bit.sv
// -----------------------------------------------------------------------------
// adder_32bit
// Purely combinational 32-bit ripple-carry adder built from full-adder cells.
// The carry out of the top bit is not produced: the result wraps mod 2^32.
// Ports:
//   a, b : input operands (32 bits)
//   sum  : a + b mod 2^32
// -----------------------------------------------------------------------------
module adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    // carry[i] is the carry into bit i; there is no carry into bit 0.
    logic [31:0] carry;

    assign carry[0] = 1'b0;

    for (genvar gi = 0; gi < 32; gi++) begin : g_sum
        assign sum[gi] = a[gi] ^ b[gi] ^ carry[gi];
    end

    for (genvar gi = 0; gi < 31; gi++) begin : g_carry
        assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end

endmodule

// File: rtl/adder_share_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// adder_share_arb_rr_pick
// Combinational round-robin picker. Searches ptr, ptr+1, ... with wrap-around
// and returns the first index whose request is valid.
// Ports:
//   req_valid : per-requester valid bits (N_REQ)
//   ptr       : index with highest priority this cycle (ID_W)
//   grant     : chosen requester index, 0 when nothing is valid (ID_W)
//   any_valid : at least one request is valid
// -----------------------------------------------------------------------------
module adder_share_arb_rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  grant,
    output logic             any_valid
);

    always_comb begin
        int idx;
        grant     = '0;
        any_valid = 1'b0;
        idx       = 0;
        // Walk from the farthest offset back to ptr so the closest valid
        // requester is the last one written and therefore wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (req_valid[idx]) begin
                grant     = ID_W'(idx);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_share_arb.sv
// -----------------------------------------------------------------------------
// adder_share_arb
// Shares one combinational 32-bit adder among N_REQ requesters using
// round-robin arbitration and valid/ready handshakes. The sum is registered
// once at the output and tagged with the producing requester's index.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   req_valid : per-requester operand valid (N_REQ)
//   req_ready : per-requester accept, at most one bit set (N_REQ)
//   req_a     : packed operand A, requester i at [32*i+31:32*i]
//   req_b     : packed operand B, same packing
//   rsp_valid : result register holds a valid sum
//   rsp_ready : consumer accepts the result
//   rsp_sum   : a + b mod 2^32
//   rsp_id    : index of the requester that produced rsp_sum (ID_W)
// -----------------------------------------------------------------------------
module adder_share_arb
    import adder_share_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*ADD_W-1:0] req_a,
    input  logic [N_REQ*ADD_W-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ADD_W-1:0]       rsp_sum,
    output logic [ID_W-1:0]        rsp_id
);

    logic [ID_W-1:0]  ptr_reg;
    logic [ID_W-1:0]  ptr_next;
    logic [ID_W-1:0]  grant;
    logic             any_valid;
    logic             can_accept;
    logic             fire;

    logic [BUS_W-1:0] a_bus;
    logic [BUS_W-1:0] b_bus;
    logic [ADD_W-1:0] op_a;
    logic [ADD_W-1:0] op_b;
    logic [ADD_W-1:0] sum;

    logic             rsp_valid_reg;
    logic [ADD_W-1:0] rsp_sum_reg;
    logic [ID_W-1:0]  rsp_id_reg;

    adder_share_arb_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req_valid (req_valid),
        .ptr       (ptr_reg),
        .grant     (grant),
        .any_valid (any_valid)
    );

    // A slot opens when the output register is empty or being drained this
    // cycle; this makes rsp_ready -> req_ready a deliberate combinational path.
    assign can_accept = !rsp_valid_reg || rsp_ready;

    // The granted requester is valid by construction, so fire is exactly the
    // handshake req_valid[g] && req_ready[g]. Nothing is accepted in reset.
    assign fire = rst_n && any_valid && can_accept;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
        assign req_ready[gi] = fire && (grant == ID_W'(gi));
    end

    // Operand mux ahead of the single shared adder.
    assign a_bus = BUS_W'(req_a);
    assign b_bus = BUS_W'(req_b);
    assign op_a  = op_slice(a_bus, int'(grant));
    assign op_b  = op_slice(b_bus, int'(grant));

    adder_32bit u_adder (
        .a   (op_a),
        .b   (op_b),
        .sum (sum)
    );

    // Pointer moves past the winner only on a completed transfer.
    always_comb begin
        ptr_next = ptr_reg;
        if (fire) begin
            if (grant == ID_W'(N_REQ - 1)) begin
                ptr_next = '0;
            end else begin
                ptr_next = grant + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_reg       <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_sum_reg   <= '0;
            rsp_id_reg    <= '0;
        end else begin
            ptr_reg <= ptr_next;
            if (fire) begin
                rsp_valid_reg <= 1'b1;
                rsp_sum_reg   <= sum;
                rsp_id_reg    <= grant;
            end else if (rsp_ready) begin
                // Drain without refill: sum and id keep their old values.
                rsp_valid_reg <= 1'b0;
            end
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_sum   = rsp_sum_reg;
    assign rsp_id    = rsp_id_reg;

endmodule

// File: tb/tb_adder_share_arb.sv
module tb_adder_share_arb;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic                clk;
    logic                rst_n;
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*32-1:0] req_a;
    logic [N_REQ*32-1:0] req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [31:0]         rsp_sum;
    logic [ID_W-1:0]     rsp_id;

    int tests_run = 0;
    int tests_failed = 0;

    adder_share_arb #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic [31:0] s, input logic [31:0] id);
        chk({tag, ".valid"}, 32'(rsp_valid), 32'(v));
        chk({tag, ".sum"}, rsp_sum, s);
        chk({tag, ".id"}, 32'(rsp_id), id);
        $display("[TB] %s: valid=%0d sum=%0h id=%0d", tag, rsp_valid, rsp_sum, rsp_id);
    endtask

    logic [31:0] fair_id  [6] = '{0, 1, 2, 3, 0, 1};
    logic [31:0] fair_sum [4] = '{32'd10, 32'd1011, 32'd2012, 32'd3013};

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < N_REQ; i++) set_op(i, 32'h1111 * (i + 1), 32'h22);

        // 1. Reset with all requests asserted.
        #2;
        chk("rst0.ready", 32'(req_ready), 32'h0);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst.ready", 32'(req_ready), 32'h0);
            chk_rsp("rst", 1'b0, 32'h0, 32'h0);
        end

        // 2. Single request from requester 2.
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b0100;
        set_op(2, 32'd5, 32'd7);
        #1;
        chk("single.ready", 32'(req_ready), 32'b0100);
        tick();
        chk_rsp("single", 1'b1, 32'd12, 32'd2);

        // Idle: nothing granted, result drains, sum/id held.
        req_valid = 4'b0000;
        #1;
        chk("idle.ready", 32'(req_ready), 32'h0);
        tick();
        chk_rsp("drain", 1'b0, 32'd12, 32'd2);

        // 3. Wrap-around sums from requester 0 (ptr is 3, wraps to 0).
        req_valid = 4'b0001;
        set_op(0, 32'hFFFF_FFFF, 32'h1);
        #1;
        chk("wrap1.ready", 32'(req_ready), 32'b0001);
        tick();
        chk_rsp("wrap1", 1'b1, 32'h0, 32'd0);
        set_op(0, 32'h8000_0000, 32'h8000_0000);
        #1;
        chk("wrap2.ready", 32'(req_ready), 32'b0001);
        tick();
        chk_rsp("wrap2", 1'b1, 32'h0, 32'd0);

        // Requester 3 alone (ptr 1 -> grant 3), leaves ptr at 0.
        req_valid = 4'b1000;
        set_op(3, 32'd100, 32'd23);
        #1;
        chk("pre.ready", 32'(req_ready), 32'b1000);
        tick();
        chk_rsp("pre", 1'b1, 32'd123, 32'd3);

        // 4. Fairness: all valid, rsp_ready high, no bubbles.
        for (int i = 0; i < N_REQ; i++) set_op(i, 32'(i + 10), 32'(i * 1000));
        req_valid = 4'b1111;
        for (int n = 0; n < 6; n++) begin
            #1;
            chk("fair.ready", 32'(req_ready), 32'(1) << fair_id[n]);
            tick();
            chk_rsp("fair", 1'b1, fair_sum[fair_id[n]], fair_id[n]);
        end

        // 5. Backpressure: result for id 1 pending, consumer stalls.
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        set_op(1, 32'h1234_0000, 32'h0000_5678);
        for (int n = 0; n < 3; n++) begin
            #1;
            chk("bp.ready", 32'(req_ready), 32'h0);
            tick();
            chk_rsp("bp.hold", 1'b1, 32'd1011, 32'd1);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp.release.ready", 32'(req_ready), 32'b0010);
        tick();
        chk_rsp("bp.new", 1'b1, 32'h1234_5678, 32'd1);

        // 6. Reset during a stall, then arbitration restarts at ptr 0.
        rsp_ready = 1'b0;
        req_valid = 4'b0000;
        tick();
        chk_rsp("stall", 1'b1, 32'h1234_5678, 32'd1);
        rst_n     = 1'b0;
        req_valid = 4'b1010;
        set_op(3, 32'd40, 32'd2);
        #1;
        chk("midrst.ready", 32'(req_ready), 32'h0);
        tick();
        chk_rsp("midrst", 1'b0, 32'h0, 32'd0);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        #1;
        chk("post.ready1", 32'(req_ready), 32'b0010);
        tick();
        chk_rsp("post1", 1'b1, 32'h1234_5678, 32'd1);
        #1;
        chk("post.ready3", 32'(req_ready), 32'b1000);
        tick();
        chk_rsp("post3", 1'b1, 32'd42, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
